// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD countdown timer: state encoding, digit constants, saturation helper.
package bcd_countdown_timer_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Clamp a nibble to the legal BCD range 0..9.
    function automatic logic [DIGIT_W-1:0] sat_digit(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle between the button front-end (master) and the timer (slave).
interface bcd_countdown_timer_if #(
    parameter int unsigned DIGITS = 2
);
    localparam int unsigned W = 4 * DIGITS;

    logic         load;
    logic [W-1:0] load_value;
    logic         start;
    logic         pause;
    logic         tick;
    logic [W-1:0] count;
    logic         running;
    logic         done;

    modport master (
        output load, load_value, start, pause, tick,
        input  count, running, done
    );

    modport slave (
        input  load, load_value, start, pause, tick,
        output count, running, done
    );
endinterface

// File: rtl/bcd_countdown_timer_digit_down.sv
// One BCD digit of a subtract-one chain: 0 wraps to 9 and propagates the borrow.
module bcd_digit_down
    import bcd_countdown_timer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] next,
    output logic       borrow_out
);

    logic [3:0] digit_sat;

    // Out-of-range input digits behave as 9.
    assign digit_sat = sat_digit(digit);

    // Decrement only when borrowed from; a zero digit wraps and borrows onward.
    assign next       = borrow_in ? ((digit_sat == 4'd0) ? BCD_MAX : (digit_sat - 4'd1)) : digit_sat;
    assign borrow_out = borrow_in & (digit == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with load, start/pause control and a one-cycle terminal-count pulse.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int unsigned DIGITS = 2
)(
    input  logic                   clk,
    input  logic                   reset,
    bcd_countdown_timer_if.slave   bus
);

    localparam int unsigned W = DIGITS * DIGIT_W;

    state_t         state_q;
    logic [W-1:0]   count_q;
    logic           running_q;
    logic           done_q;

    logic [W-1:0]   dec_c;
    logic [W-1:0]   sat_c;
    logic [DIGITS:0] borrow_c;
    logic           zero_c;
    logic           one_c;

    // The chain always subtracts one; the final borrow only survives when every digit is 0.
    assign borrow_c[0] = 1'b1;

    // Per-digit decrement and load saturation.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_down u_digit (
            .digit      (count_q[i*DIGIT_W +: DIGIT_W]),
            .borrow_in  (borrow_c[i]),
            .next       (dec_c[i*DIGIT_W +: DIGIT_W]),
            .borrow_out (borrow_c[i+1])
        );
        assign sat_c[i*DIGIT_W +: DIGIT_W] = sat_digit(bus.load_value[i*DIGIT_W +: DIGIT_W]);
    end

    // Zero falls out of the borrow chain; one marks the terminal tick.
    assign zero_c = borrow_c[DIGITS];
    assign one_c  = (count_q == W'(1));

    // Control FSM with registered count, running and done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                count_q   <= sat_c;
                state_q   <= ST_IDLE;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (bus.pause) begin
                            state_q   <= ST_HOLD;
                            running_q <= 1'b0;
                        end else if (bus.tick) begin
                            count_q <= dec_c;
                            if (one_c) begin
                                state_q   <= ST_IDLE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end
                    end
                    ST_IDLE, ST_HOLD: begin
                        if (bus.start && !zero_c) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.count   = count_q;
    assign bus.running = running_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench: a 2-digit and a 3-digit timer driven in lockstep against a decimal model.
module tb_bcd_countdown_timer;

    logic clk;
    logic reset;

    bcd_countdown_timer_if #(.DIGITS(2)) bus2 ();
    bcd_countdown_timer_if #(.DIGITS(3)) bus3 ();

    bcd_countdown_timer #(.DIGITS(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
    bcd_countdown_timer #(.DIGITS(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Model state: remaining time as a plain integer, plus running and done flags.
    int m_val  [2];
    bit m_run  [2];
    bit m_done [2];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int bcd_to_int(input logic [11:0] v, input int nd);
        int sum = 0;
        int w   = 1;
        for (int i = 0; i < nd; i++) begin
            int d = int'((v >> (4*i)) & 12'hF);
            if (d > 9) d = 9;
            sum += d * w;
            w *= 10;
        end
        return sum;
    endfunction

    function automatic int int_to_bcd(input int x);
        int r = 0;
        int y = x;
        for (int i = 0; i < 3; i++) begin
            r |= (y % 10) << (4*i);
            y /= 10;
        end
        return r;
    endfunction

    // Reference behaviour, applied to the inputs sampled at each rising edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_val[k]  <= 0;
                m_run[k]  <= 1'b0;
                m_done[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int v;
                bit r;
                bit dn;
                logic [11:0] lv;
                v  = m_val[k];
                r  = m_run[k];
                dn = 1'b0;
                lv = (k == 0) ? {4'h0, bus3.load_value[7:0]} : bus3.load_value;
                if (bus3.load) begin
                    v = bcd_to_int(lv, (k == 0) ? 2 : 3);
                    r = 1'b0;
                end else if (r && bus3.pause) begin
                    r = 1'b0;
                end else if (r && bus3.tick) begin
                    v = v - 1;
                    if (v == 0) begin
                        r  = 1'b0;
                        dn = 1'b1;
                    end
                end else if (!r && bus3.start && v != 0) begin
                    r = 1'b1;
                end
                m_val[k]  <= v;
                m_run[k]  <= r;
                m_done[k] <= dn;
            end
        end
    end

    // Cycle-by-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model count2",   int'(bus2.count),   int_to_bcd(m_val[0]));
            chk("model running2", int'(bus2.running), int'(m_run[0]));
            chk("model done2",    int'(bus2.done),    int'(m_done[0]));
            chk("model count3",   int'(bus3.count),   int_to_bcd(m_val[1]));
            chk("model running3", int'(bus3.running), int'(m_run[1]));
            chk("model done3",    int'(bus3.done),    int'(m_done[1]));
        end
    end

    // One clock of stimulus, strobes cleared just after the edge.
    task automatic step(input bit l, input logic [11:0] lv, input bit s, input bit p, input bit t);
        bus2.load = l;  bus2.load_value = lv[7:0]; bus2.start = s; bus2.pause = p; bus2.tick = t;
        bus3.load = l;  bus3.load_value = lv;      bus3.start = s; bus3.pause = p; bus3.tick = t;
        @(posedge clk);
        #1;
        bus2.load = 1'b0; bus2.start = 1'b0; bus2.pause = 1'b0; bus2.tick = 1'b0;
        bus3.load = 1'b0; bus3.start = 1'b0; bus3.pause = 1'b0; bus3.tick = 1'b0;
    endtask

    task automatic ld(input logic [11:0] v); step(1'b1, v, 1'b0, 1'b0, 1'b0); endtask
    task automatic st();  step(1'b0, 12'h0, 1'b1, 1'b0, 1'b0); endtask
    task automatic ps();  step(1'b0, 12'h0, 1'b0, 1'b1, 1'b0); endtask
    task automatic tk();  step(1'b0, 12'h0, 1'b0, 1'b0, 1'b1); endtask
    task automatic nop(); step(1'b0, 12'h0, 1'b0, 1'b0, 1'b0); endtask

    int exp_seq [12] = '{'h011, 'h010, 'h009, 'h008, 'h007, 'h006,
                         'h005, 'h004, 'h003, 'h002, 'h001, 'h000};

    initial begin
        reset = 1'b1;
        bus2.load = 1'b0; bus2.load_value = '0; bus2.start = 1'b0; bus2.pause = 1'b0; bus2.tick = 1'b0;
        bus3.load = 1'b0; bus3.load_value = '0; bus3.start = 1'b0; bus3.pause = 1'b0; bus3.tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset count",   int'(bus3.count),   'h000);
        chk("reset running", int'(bus3.running), 0);
        chk("reset done",    int'(bus3.done),    0);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Reset in the middle of a run clears outputs without a clock edge.
        ld(12'h005); st(); tk(); tk();
        chk("pre-reset count", int'(bus3.count), 'h003);
        #1 reset = 1'b1;
        #1;
        chk("async reset count3",   int'(bus3.count),   'h000);
        chk("async reset running3", int'(bus3.running), 0);
        chk("async reset count2",   int'(bus2.count),   'h00);
        reset = 1'b0;
        st();
        chk("start at zero ignored", int'(bus3.running), 0);

        // Full countdown from 12 with back-to-back ticks.
        ld(12'h012); st();
        chk("start -> running", int'(bus3.running), 1);
        for (int i = 0; i < 12; i++) begin
            tk();
            chk("countdown count3", int'(bus3.count), exp_seq[i]);
            chk("countdown count2", int'(bus2.count), exp_seq[i] & 'hFF);
            chk("countdown done",   int'(bus3.done),  (i == 11) ? 1 : 0);
            chk("countdown running", int'(bus3.running), (i == 11) ? 0 : 1);
        end
        nop();
        chk("done one cycle", int'(bus3.done), 0);

        // Borrow across two digits; 0x100 truncates to zero on the 2-digit timer.
        ld(12'h100); st(); tk();
        chk("borrow 100->099", int'(bus3.count), 'h099);
        chk("2-digit zero stays idle", int'(bus2.running), 0);
        ld(12'h000); st();
        chk("load 0 start idle", int'(bus3.running), 0);

        // Load saturation of non-BCD digits.
        ld(12'hFAF);
        chk("sat FAF 3-digit", int'(bus3.count), 'h999);
        chk("sat AF 2-digit",  int'(bus2.count), 'h99);
        ld(12'h0AF);
        chk("sat 0AF 3-digit", int'(bus3.count), 'h099);

        // Pause, ignored ticks, resume, simultaneous strobes.
        ld(12'h030); st(); tk();
        chk("30->29", int'(bus3.count), 'h029);
        ps();
        repeat (5) tk();
        chk("hold count",   int'(bus3.count),   'h029);
        chk("hold running", int'(bus3.running), 0);
        step(1'b0, 12'h0, 1'b1, 1'b0, 1'b1);
        chk("start+tick count",   int'(bus3.count),   'h029);
        chk("start+tick running", int'(bus3.running), 1);
        tk();
        chk("resume 29->28", int'(bus3.count), 'h028);
        step(1'b0, 12'h0, 1'b1, 1'b1, 1'b0);
        chk("start+pause in run", int'(bus3.running), 0);
        tk();
        chk("hold after start+pause", int'(bus3.count), 'h028);

        // Load on the terminal tick wins over done.
        ld(12'h001); st();
        step(1'b1, 12'h045, 1'b0, 1'b0, 1'b1);
        chk("load on terminal count", int'(bus3.count),   'h045);
        chk("load on terminal done",  int'(bus3.done),    0);
        chk("load on terminal run",   int'(bus3.running), 0);
        nop(); nop();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Multi-digit BCD down-counter with load, start/pause control and a terminal-count pulse. It is the count-down companion to the lab's mod-10 up-counter next-state logic: the same 0–9 digit encoding, decremented instead of incremented, with borrow chained across digits. It sits between the board's debounced button/switch inputs and the seven-segment display driver, and supplies a kitchen-timer style countdown.

## Interface
- DIGITS, 2, number of BCD digits (1–4); count width is 4*DIGITS.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- load  in  1  one-cycle strobe; captures load_value.
- load_value  in  4*DIGITS  preset value, digit i at bits [4i+3:4i].
- start  in  1  one-cycle strobe; begin or resume counting.
- pause  in  1  one-cycle strobe; suspend counting.
- tick  in  1  count enable, for example a 1 Hz strobe; one decrement per high cycle while running.
- count  out  4*DIGITS  current BCD value; always valid BCD.
- running  out  1  high while in RUN.
- done  out  1  one-cycle pulse when the count reaches zero.

## Operation
- States:
  - IDLE: stopped, awaiting start.
  - RUN: counting.
  - HOLD: paused.
- Reset (async): count=0, state=IDLE, running=0, done=0.
- Priority per cycle, highest first: load, then start/pause, then tick.
- load, in any state:
  - count ← load_value, with every digit >9 saturated to 9.
  - state → IDLE; done=0.
  - start, pause and tick in the same cycle are ignored.
- start:
  - IDLE or HOLD with count≠0 → RUN.
  - start while count==0 is ignored and the block stays in IDLE.
  - start while in RUN has no effect.
- pause:
  - RUN → HOLD.
  - Ignored in IDLE and HOLD.
  - If start and pause arrive together: pause wins in RUN, start wins in IDLE or HOLD.
- tick:
  - Acts only when the state is RUN at the start of the cycle and no start, pause or load transition occurs in that cycle.
  - A start cycle never decrements.
- Decrement: BCD subtract-one.
  - The least significant digit 0 wraps to 9 and borrows into the next digit.
  - A digit >0 decrements and stops the borrow chain.
  - Example: 0x20 → 0x19, 0x10 → 0x09.
- Terminal count: when count==1 (all upper digits 0, LSD 1) and a tick is accepted:
  - count → 0.
  - state → IDLE.
  - done=1 for exactly the following cycle.
- The count never underflows; 0 in RUN is unreachable.
- Tick while in IDLE or HOLD: count is unchanged.

## Timing
- All outputs are registered. count, running and done change only on the rising edge of clk, except under asynchronous reset.
- Latency is 1 cycle from a sampled strobe to the updated output:
  - tick at edge N gives the new count after N.
  - start at N gives running=1 after N.
- done is high in the same cycle that count first shows 0; it drops the next cycle.
- Reset asserted mid-count: outputs clear immediately without waiting for clk. After release, the first active edge behaves as from IDLE with count=0.
- Back-to-back ticks decrement on every cycle; no idle cycle is required.
- load in the same cycle as a terminal tick: load wins, done stays 0, count=load_value.

## Structure
- Shared package/header `timer_defs`:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_HOLD=2'd2.
  - BCD_MAX=4'd9.
  - Digit width constant 4.
- Sub-module `bcd_digit_down`, combinational, one instance per digit in a generate loop:
  - Inputs: digit[3:0], borrow_in.
  - Outputs: next[3:0], borrow_out.
  - borrow_in=0 means pass the digit through.
  - borrow_out = borrow_in and digit==0.
  - An input digit >9 maps to 9.
- Top level: state register, count register, load saturation, zero/one detect, done register.

## Test plan
- Reset mid-run: load 0x05, start, 2 ticks (count 0x03), assert reset between edges → count=0x00, running=0 immediately; start afterwards is ignored.
- Full countdown: load 0x12, start, 12 ticks → count sequence 0x11, 0x10, 0x09 … 0x01, 0x00; done is high for exactly one cycle with count=0x00; running drops on the same edge.
- Borrow chain (DIGITS=3): load 0x100, start, 1 tick → 0x099; load 0x000 then start → stays IDLE, running=0.
- Saturation: load_value=0xAF (DIGITS=2) → count=0x99.
- Pause/resume: load 0x30, start, tick→0x29, pause, 5 ticks → holds 0x29; start, tick → 0x28.
- Simultaneous events:
  - start+pause in RUN → HOLD.
  - start+tick from HOLD at 0x29 → RUN, count stays 0x29.
  - load 0x45 on the terminal tick from 0x01 → count=0x45, done=0.
